// File: rtl/ram_arb_pkg.sv
// Shared constants and types for the dual-port RAM read/write arbiter.
package ram_arb_pkg;

    localparam int DATA_WIDTH_DEF = 32;
    localparam int LENGTH_DEF     = 1536;
    localparam int NREQ           = 2;

    typedef logic req_id_t;

    function automatic logic in_range(input logic [31:0] addr, input int len);
        return addr < 32'(len);
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter with a registered last-winner pointer.
module rr_arb2
    import ram_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    output logic [1:0] gnt,
    output logic       sel
);

    req_id_t last;

    always_comb begin
        sel = req[1];
        if (req == 2'b11)
            sel = ~last;
        gnt = 2'b00;
        if (|req)
            gnt[sel] = 1'b1;
    end

    // last=1 after reset so requester 0 is the next winner
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            last <= 1'b1;
        else if (|req)
            last <= sel;
    end

endmodule

// File: rtl/ram_rw_arbiter.sv
// Arbitrates two read and two write requesters onto one simple dual-port RAM,
// with read-during-write bypass and out-of-range address reporting.
module ram_rw_arbiter
    import ram_arb_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int LENGTH     = LENGTH_DEF
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NREQ-1:0]                rd_req,
    input  logic [NREQ-1:0][31:0]          rd_addr,
    output logic [NREQ-1:0]                rd_gnt,
    output logic [NREQ-1:0]                rd_valid,
    output logic                           rd_err,
    output logic [DATA_WIDTH-1:0]          rd_data,
    input  logic [NREQ-1:0]                wr_req,
    input  logic [NREQ-1:0][31:0]          wr_addr,
    input  logic [NREQ-1:0][DATA_WIDTH-1:0] wr_data,
    output logic [NREQ-1:0]                wr_gnt,
    output logic                           wr_err,
    output logic                           ram_we,
    output logic [31:0]                    ram_w_addr,
    output logic [DATA_WIDTH-1:0]          ram_wd,
    output logic [31:0]                    ram_r_addr,
    input  logic [DATA_WIDTH-1:0]          ram_rd
);

    req_id_t               rd_sel;
    req_id_t               wr_sel;
    logic [31:0]           rd_a;
    logic [31:0]           r_addr_q;
    logic                  rd_ok;
    logic                  wr_ok;
    logic                  bypass;
    logic                  bypass_q;
    logic [DATA_WIDTH-1:0] bypass_data;

    rr_arb2 u_rd_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (rd_req),
        .gnt   (rd_gnt),
        .sel   (rd_sel)
    );

    rr_arb2 u_wr_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (wr_req),
        .gnt   (wr_gnt),
        .sel   (wr_sel)
    );

    assign rd_a       = rd_addr[rd_sel];
    assign rd_ok      = in_range(rd_a, LENGTH);
    assign ram_r_addr = (|rd_gnt) ? rd_a : r_addr_q;

    assign ram_w_addr = wr_addr[wr_sel];
    assign ram_wd     = wr_data[wr_sel];
    assign wr_ok      = in_range(ram_w_addr, LENGTH);
    assign ram_we     = rst_n & (|wr_gnt) & wr_ok;
    assign wr_err     = (|wr_gnt) & ~wr_ok;

    // RAM returns old data on a same-address collision, so forward the write
    assign bypass = (|rd_gnt) & rd_ok & ram_we & (rd_a == ram_w_addr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid    <= '0;
            rd_err      <= 1'b0;
            bypass_q    <= 1'b0;
            bypass_data <= '0;
            r_addr_q    <= '0;
        end else begin
            rd_valid <= rd_gnt;
            rd_err   <= (|rd_gnt) & ~rd_ok;
            bypass_q <= bypass;
            if (bypass)
                bypass_data <= ram_wd;
            if (|rd_gnt)
                r_addr_q <= rd_a;
        end
    end

    assign rd_data = rd_err   ? '0 :
                     bypass_q ? bypass_data : ram_rd;

endmodule

// File: tb/tb_ram_rw_arbiter.sv
// Self-checking bench for ram_rw_arbiter: directed scenarios plus
// randomized traffic against a behavioural arbitration/memory model.
module tb_ram_rw_arbiter;

    localparam int DW  = 32;
    localparam int LEN = 1536;
    localparam int AW  = 11;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [1:0] rd_req, rd_gnt, rd_valid, wr_req, wr_gnt;
    logic [1:0][31:0] rd_addr, wr_addr;
    logic [1:0][DW-1:0] wr_data;
    logic rd_err, wr_err, ram_we;
    logic [DW-1:0] rd_data, ram_wd, ram_rd;
    logic [31:0] ram_w_addr, ram_r_addr;

    logic [DW-1:0] mem [LEN];

    int errors = 0;
    int checks = 0;

    // reference model state
    int rptr, wptr;
    logic [31:0] last_raddr;
    logic [DW-1:0] ref_mem [LEN];
    logic [1:0] m_rgnt, m_wgnt;
    logic m_we, m_werr;
    logic [31:0] m_raddr, m_waddr;
    logic [DW-1:0] m_wd;
    logic [1:0] nx_rv, pend_rv;
    logic nx_rerr, pend_rerr;
    logic [DW-1:0] nx_rdata, pend_rdata;

    ram_rw_arbiter #(.DATA_WIDTH(DW), .LENGTH(LEN)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rd_req     (rd_req),
        .rd_addr    (rd_addr),
        .rd_gnt     (rd_gnt),
        .rd_valid   (rd_valid),
        .rd_err     (rd_err),
        .rd_data    (rd_data),
        .wr_req     (wr_req),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_gnt     (wr_gnt),
        .wr_err     (wr_err),
        .ram_we     (ram_we),
        .ram_w_addr (ram_w_addr),
        .ram_wd     (ram_wd),
        .ram_r_addr (ram_r_addr),
        .ram_rd     (ram_rd)
    );

    always #5 clk = ~clk;

    // RAM with registered read; same-address read returns old contents
    always @(posedge clk) begin
        if (ram_we && ram_w_addr < LEN)
            mem[ram_w_addr[AW-1:0]] <= ram_wd;
        ram_rd <= (ram_r_addr < LEN) ? mem[ram_r_addr[AW-1:0]] : 32'hBAD0_BAD0;
    end

    function automatic logic [1:0] pick(input logic [1:0] req, input int nxt);
        if (req == 2'b11)
            return (nxt == 0) ? 2'b01 : 2'b10;
        return req;
    endfunction

    task automatic model_reset();
        rptr = 0;
        wptr = 0;
        last_raddr = '0;
        pend_rv = '0;
        pend_rerr = 1'b0;
        pend_rdata = '0;
        m_rgnt = '0;
        m_wgnt = '0;
        m_we = 1'b0;
    endtask

    task automatic predict();
        logic [31:0] ra;
        m_rgnt = pick(rd_req, rptr);
        m_wgnt = pick(wr_req, wptr);
        ra = rd_addr[m_rgnt[1]];
        m_waddr = wr_addr[m_wgnt[1]];
        m_wd = wr_data[m_wgnt[1]];
        m_we = (m_wgnt != 0) && (m_waddr < LEN);
        m_werr = (m_wgnt != 0) && (m_waddr >= LEN);
        m_raddr = (m_rgnt != 0) ? ra : last_raddr;
        nx_rv = m_rgnt;
        nx_rerr = (m_rgnt != 0) && (ra >= LEN);
        if (nx_rerr || m_rgnt == 0)
            nx_rdata = '0;
        else if (m_we && m_waddr == ra)
            nx_rdata = m_wd;
        else
            nx_rdata = ref_mem[ra[AW-1:0]];
    endtask

    task automatic settle();
        #1;
        predict();
    endtask

    task automatic advance();
        @(posedge clk);
        if (m_rgnt != 0) begin
            rptr = m_rgnt[0] ? 1 : 0;
            last_raddr = m_raddr;
        end
        if (m_wgnt != 0)
            wptr = m_wgnt[0] ? 1 : 0;
        if (m_we)
            ref_mem[m_waddr[AW-1:0]] = m_wd;
        pend_rv = nx_rv;
        pend_rerr = nx_rerr;
        pend_rdata = nx_rdata;
        #1;
    endtask

    task automatic idle_inputs();
        rd_req = '0;
        wr_req = '0;
    endtask

    function automatic logic [31:0] rand_addr();
        if ($urandom_range(0, 9) == 0)
            return 32'($urandom_range(LEN - 2, LEN + 2));
        return 32'($urandom_range(0, 15));
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        rd_req = 2'b11;
        rd_addr[0] = 32'd4;
        rd_addr[1] = 32'd3;
        wr_req = 2'b11;
        wr_addr[0] = 32'd1;
        wr_addr[1] = 32'd2;
        wr_data[0] = 32'h1111_1111;
        wr_data[1] = 32'h2222_2222;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (ram_we !== 1'b0) begin
            errors++;
            $display("FAIL reset_we: got %b want 0", ram_we);
        end
        checks++;
        if (rd_valid !== 2'b00 || rd_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_rd: got valid=%b err=%b want 00/0", rd_valid, rd_err);
        end
        checks++;
        if (rd_gnt !== 2'b01 || wr_gnt !== 2'b01) begin
            errors++;
            $display("FAIL reset_ptr: got rd=%b wr=%b want 01/01", rd_gnt, wr_gnt);
        end
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        checks++;
        if (rd_valid !== 2'b00) begin
            errors++;
            $display("FAIL reset_release: got %b want 00", rd_valid);
        end
    endtask

    task automatic test_single_read();
        rd_req = 2'b01;
        rd_addr[0] = 32'd5;
        settle();
        checks++;
        if (rd_gnt !== 2'b01 || ram_r_addr !== 32'd5) begin
            errors++;
            $display("FAIL single_gnt: got %b addr %0d want 01 addr 5", rd_gnt, ram_r_addr);
        end
        advance();
        idle_inputs();
        checks++;
        if (rd_valid !== 2'b01 || rd_err !== 1'b0 || rd_data !== ref_mem[5]) begin
            errors++;
            $display("FAIL single_data: got v=%b e=%b d=%h want 01/0/%h",
                     rd_valid, rd_err, rd_data, ref_mem[5]);
        end
        settle();
        checks++;
        if (ram_r_addr !== 32'd5) begin
            errors++;
            $display("FAIL r_addr_hold: got %0d want 5", ram_r_addr);
        end
        advance();
    endtask

    task automatic test_write_rr();
        logic [1:0] seq [4];
        logic [31:0] addr_exp;
        seq = '{2'b01, 2'b10, 2'b01, 2'b10};
        wr_req = 2'b11;
        wr_addr[0] = 32'd10;
        wr_addr[1] = 32'd11;
        wr_data[0] = 32'hAAAA_0A0A;
        wr_data[1] = 32'hBBBB_0B0B;
        for (int i = 0; i < 4; i++) begin
            settle();
            addr_exp = (seq[i] == 2'b01) ? 32'd10 : 32'd11;
            checks++;
            if (wr_gnt !== seq[i] || ram_we !== 1'b1 || ram_w_addr !== addr_exp) begin
                errors++;
                $display("FAIL wr_rr[%0d]: got gnt=%b we=%b a=%0d want %b/1/%0d",
                         i, wr_gnt, ram_we, ram_w_addr, seq[i], addr_exp);
            end
            advance();
        end
        wr_req = 2'b00;
        rd_req = 2'b01;
        rd_addr[0] = 32'd10;
        settle();
        advance();
        rd_addr[0] = 32'd11;
        checks++;
        if (rd_data !== 32'hAAAA_0A0A) begin
            errors++;
            $display("FAIL wr_rr_mem10: got %h want aaaa0a0a", rd_data);
        end
        settle();
        advance();
        idle_inputs();
        checks++;
        if (rd_data !== 32'hBBBB_0B0B) begin
            errors++;
            $display("FAIL wr_rr_mem11: got %h want bbbb0b0b", rd_data);
        end
    endtask

    task automatic test_bypass();
        wr_req = 2'b01;
        wr_addr[0] = 32'd20;
        wr_data[0] = 32'hDEAD_BEEF;
        rd_req = 2'b10;
        rd_addr[1] = 32'd20;
        settle();
        checks++;
        if (rd_gnt !== 2'b10 || wr_gnt !== 2'b01 || ram_we !== 1'b1) begin
            errors++;
            $display("FAIL bypass_gnt: got rd=%b wr=%b we=%b want 10/01/1", rd_gnt, wr_gnt, ram_we);
        end
        advance();
        idle_inputs();
        checks++;
        if (rd_valid !== 2'b10 || rd_data !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL bypass_data: got v=%b d=%h want 10/deadbeef", rd_valid, rd_data);
        end
        rd_req = 2'b01;
        rd_addr[0] = 32'd20;
        settle();
        advance();
        idle_inputs();
        checks++;
        if (rd_data !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL bypass_commit: got %h want deadbeef", rd_data);
        end
    endtask

    task automatic test_out_of_range();
        wr_req = 2'b10;
        wr_addr[1] = 32'd1536;
        wr_data[1] = 32'h5555_5555;
        rd_req = 2'b01;
        rd_addr[0] = 32'd2000;
        settle();
        checks++;
        if (wr_gnt !== 2'b10 || wr_err !== 1'b1 || ram_we !== 1'b0) begin
            errors++;
            $display("FAIL oor_wr: got gnt=%b err=%b we=%b want 10/1/0", wr_gnt, wr_err, ram_we);
        end
        advance();
        checks++;
        if (rd_valid !== 2'b01 || rd_err !== 1'b1 || rd_data !== '0) begin
            errors++;
            $display("FAIL oor_rd: got v=%b e=%b d=%h want 01/1/0", rd_valid, rd_err, rd_data);
        end
        wr_addr[1] = 32'd1535;
        rd_addr[0] = 32'd1535;
        settle();
        checks++;
        if (wr_err !== 1'b0 || ram_we !== 1'b1) begin
            errors++;
            $display("FAIL edge_wr: got err=%b we=%b want 0/1", wr_err, ram_we);
        end
        advance();
        idle_inputs();
        checks++;
        if (rd_err !== 1'b0 || rd_data !== 32'h5555_5555) begin
            errors++;
            $display("FAIL edge_rd: got e=%b d=%h want 0/55555555", rd_err, rd_data);
        end
    endtask

    task automatic test_reset_mid();
        rd_req = 2'b01;
        rd_addr[0] = 32'd7;
        settle();
        advance();
        idle_inputs();
        checks++;
        if (rd_valid !== 2'b01) begin
            errors++;
            $display("FAIL mid_pre: got %b want 01", rd_valid);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (rd_valid !== 2'b00) begin
            errors++;
            $display("FAIL mid_async: got %b want 00", rd_valid);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        checks++;
        if (rd_valid !== 2'b00) begin
            errors++;
            $display("FAIL mid_release: got %b want 00", rd_valid);
        end
        rd_req = 2'b11;
        rd_addr[0] = 32'd1;
        rd_addr[1] = 32'd2;
        wr_req = 2'b11;
        wr_addr[0] = 32'd3;
        wr_addr[1] = 32'd4;
        settle();
        checks++;
        if (rd_gnt !== 2'b01 || wr_gnt !== 2'b01) begin
            errors++;
            $display("FAIL mid_first: got rd=%b wr=%b want 01/01", rd_gnt, wr_gnt);
        end
        advance();
        idle_inputs();
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            rd_req = 2'($urandom_range(0, 3));
            wr_req = 2'($urandom_range(0, 3));
            for (int i = 0; i < 2; i++) begin
                rd_addr[i] = rand_addr();
                wr_addr[i] = rand_addr();
                wr_data[i] = $urandom;
            end
            settle();
            checks++;
            if (rd_valid !== pend_rv || rd_err !== pend_rerr) begin
                errors++;
                $display("FAIL rnd_valid[%0d]: got %b/%b want %b/%b",
                         n, rd_valid, rd_err, pend_rv, pend_rerr);
            end
            if (pend_rv != 0) begin
                checks++;
                if (rd_data !== pend_rdata) begin
                    errors++;
                    $display("FAIL rnd_data[%0d]: got %h want %h", n, rd_data, pend_rdata);
                end
            end
            checks++;
            if (rd_gnt !== m_rgnt || wr_gnt !== m_wgnt) begin
                errors++;
                $display("FAIL rnd_gnt[%0d]: got %b/%b want %b/%b",
                         n, rd_gnt, wr_gnt, m_rgnt, m_wgnt);
            end
            checks++;
            if (ram_we !== m_we || wr_err !== m_werr || ram_r_addr !== m_raddr) begin
                errors++;
                $display("FAIL rnd_ctl[%0d]: got we=%b err=%b ra=%0d want %b/%b/%0d",
                         n, ram_we, wr_err, ram_r_addr, m_we, m_werr, m_raddr);
            end
            if (m_we) begin
                checks++;
                if (ram_w_addr !== m_waddr || ram_wd !== m_wd) begin
                    errors++;
                    $display("FAIL rnd_wr[%0d]: got %0d/%h want %0d/%h",
                             n, ram_w_addr, ram_wd, m_waddr, m_wd);
                end
            end
            advance();
        end
        idle_inputs();
    endtask

    initial begin
        logic [DW-1:0] v;
        for (int i = 0; i < LEN; i++) begin
            v = $urandom;
            mem[i] <= v;
            ref_mem[i] = v;
        end
        model_reset();
        test_reset();
        test_single_read();
        test_write_rr();
        test_bypass();
        test_out_of_range();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ram_rw_arbiter.md
RAM_RW_ARBITER -- requirements
Module: ram_rw_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, meaning RAM word width.
REQ-002 The block SHALL have parameter LENGTH, default 1536 (256*6), meaning number of RAM words; addresses >= LENGTH are out of range.
REQ-003 clk  input  1  single clock for all logic; the shared RAM's r_clk and w_clk are both tied to clk.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 rd_req  input  2  per-requester read request; bit i = requester i; held until granted.
REQ-006 rd_addr  input  2x32  per-requester read word address.
REQ-007 rd_gnt  output  2  one-hot read grant, same cycle as accepted request.
REQ-008 rd_valid  output  2  one-hot read-data-valid, one cycle after grant.
REQ-009 rd_err  output  1  qualifies rd_valid; 1 = granted address was out of range.
REQ-010 rd_data  output  DATA_WIDTH  read data, broadcast to both requesters; meaningful only with rd_valid.
REQ-011 wr_req  input  2  per-requester write request; held until granted.
REQ-012 wr_addr  input  2x32  per-requester write word address.
REQ-013 wr_data  input  2xDATA_WIDTH  per-requester write data.
REQ-014 wr_gnt  output  2  one-hot write grant; the write is committed at the edge ending the grant cycle.
REQ-015 wr_err  output  1  pulses with wr_gnt when the granted address is out of range.
REQ-016 ram_we  output  1  RAM write enable.
REQ-017 ram_w_addr  output  32  RAM write address.
REQ-018 ram_wd  output  DATA_WIDTH  RAM write data.
REQ-019 ram_r_addr  output  32  RAM read address.
REQ-020 ram_rd  input  DATA_WIDTH  RAM registered read data, valid the cycle after ram_r_addr is presented.

Function
REQ-021 Read and write ports SHALL be arbitrated independently, each by a two-way round-robin with a registered last-winner pointer.
REQ-022 With one requester active, that requester SHALL be granted that cycle; with both active, the requester that did not win last SHALL be granted, and the pointer SHALL update on every grant.
REQ-023 A continuously requesting requester SHALL be granted within 2 cycles (no starvation).
REQ-024 rd_gnt, wr_gnt, ram_r_addr, ram_w_addr, ram_wd and ram_we SHALL be combinational from the current requests and pointers; at most one bit of each grant vector is high.
REQ-025 ram_we SHALL equal |wr_gnt AND the granted address < LENGTH; out-of-range writes SHALL be dropped and wr_err pulsed.
REQ-026 rd_valid SHALL be the registered copy of rd_gnt; rd_err SHALL be registered from the out-of-range check; rd_data SHALL be 0 when rd_err=1.
REQ-027 Read-during-write bypass: when a read and an in-range write are granted the same cycle to the same address, the registered write data SHALL be returned on rd_data the next cycle instead of ram_rd (old data).
REQ-028 With no read granted, ram_r_addr SHALL hold its last value; with no write granted, ram_w_addr/ram_wd are don't-care but ram_we=0.
REQ-029 Throughput SHALL be one read and one write per cycle sustained.

Reset
REQ-030 On rst_n low, immediately and independent of clk: both pointers select requester 0 as next winner; rd_valid=0, rd_err=0, bypass flag=0.
REQ-031 Reset mid-operation SHALL discard any in-flight read response (no rd_valid after rst_n release); ram_we SHALL be 0 while rst_n is low.

Structure
REQ-032 Package ram_arb_pkg SHALL hold DATA_WIDTH_DEF=32, LENGTH_DEF=1536, NREQ=2 and the req_id_t typedef (1 bit).
REQ-033 Sub-module rr_arb2 (two requests, one-hot grant, pointer register) SHALL be instantiated once for read and once for write.

Verification
REQ-034 Reset, then rd_req=01, addr 5 -> rd_gnt=01 same cycle; rd_valid=01 next cycle with RAM word 5.
REQ-035 Both wr_req held 4 cycles, addrs 10/11, data A/B -> wr_gnt 01,10,01,10; RAM[10]=A, RAM[11]=B.
REQ-036 wr_req=01 addr 20 data 0xDEADBEEF and rd_req=10 addr 20 same cycle -> rd_valid=10 next cycle, rd_data=0xDEADBEEF.
REQ-037 wr addr 1536 -> wr_gnt, wr_err=1, ram_we=0; rd addr 2000 -> rd_valid with rd_err=1, rd_data=0.
REQ-038 rst_n low the cycle after a read grant -> rd_valid stays 0; first grant after release goes to requester 0 when both request.
